dmem_port_arbiter: RTL

//  Shares the single-port data memory between two requesters: the core load/store unit (port C)
//  and a debug/DMA master (port D) that preloads or dumps memory.

---
 rtl/dmem_arb_pkg.sv | 23 ++
 rtl/dmem_port_arbiter_if.sv | 50 +++++
 rtl/dmem_arb_starve_cnt.sv | 27 ++
 rtl/dmem_port_arbiter.sv | 112 +++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port arbiter: FSM state and read-response tag encodings.
package dmem_arb_pkg;

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    DLOCK = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_C    = 2'd1,
    TAG_D    = 2'd2
  } rtag_e;

  // All-zero strobes mean the access is a read.
  function automatic logic is_read(input logic [SW-1:0] wstb);
    return wstb == '0;
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of core port (C_*), debug port (D_*) and memory port (M_*) signals around the arbiter.
interface dmem_port_arbiter_if #(
  parameter int unsigned AW = 30
);
  import dmem_arb_pkg::*;

  logic          C_REQ;
  logic [SW-1:0] C_WSTB;
  logic [AW-1:0] C_ADDR;
  logic [DW-1:0] C_WDATA;
  logic          C_GNT;
  logic          C_RVALID;
  logic [DW-1:0] C_RDATA;

  logic          D_REQ;
  logic [SW-1:0] D_WSTB;
  logic [AW-1:0] D_ADDR;
  logic [DW-1:0] D_WDATA;
  logic          D_GNT;
  logic          D_RVALID;
  logic [DW-1:0] D_RDATA;
  logic          D_LOCK;

  logic          M_EN;
  logic [SW-1:0] M_WSTB;
  logic [AW-1:0] M_ADDR;
  logic [DW-1:0] M_WDATA;
  logic [DW-1:0] M_RDATA;

  // Arbiter side.
  modport slave (
    input  C_REQ, C_WSTB, C_ADDR, C_WDATA,
    output C_GNT, C_RVALID, C_RDATA,
    input  D_REQ, D_WSTB, D_ADDR, D_WDATA, D_LOCK,
    output D_GNT, D_RVALID, D_RDATA,
    output M_EN, M_WSTB, M_ADDR, M_WDATA,
    input  M_RDATA
  );

  // Requester / memory side.
  modport master (
    output C_REQ, C_WSTB, C_ADDR, C_WDATA,
    input  C_GNT, C_RVALID, C_RDATA,
    output D_REQ, D_WSTB, D_ADDR, D_WDATA, D_LOCK,
    input  D_GNT, D_RVALID, D_RDATA,
    input  M_EN, M_WSTB, M_ADDR, M_WDATA,
    output M_RDATA
  );

endinterface

// File: rtl/dmem_arb_starve_cnt.sv
// Saturating count of consecutive cycles the debug port was denied while requesting.
module dmem_arb_starve_cnt #(
  parameter int unsigned MAX_WAIT = 8,
  localparam int unsigned CW = $clog2(MAX_WAIT + 1)
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic clr,
  input  logic inc,
  output logic sat_c
);

  logic [CW-1:0] cnt;

  assign sat_c = (cnt == CW'(MAX_WAIT));

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat_c) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter for the single-port data memory: core priority, debug starvation guard and lock.
// Optional DMEM_ARB_PERF_EN adds grant/stall performance counters.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW       = 30,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic                CLK,
  input  logic                RSTN,
  dmem_port_arbiter_if.slave  bus
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]         PERF_C_GNT,
  output logic [31:0]         PERF_D_GNT,
  output logic [31:0]         PERF_C_STALL
`endif
);

  arb_state_e    state_q, state_d;
  rtag_e         rtag_q, rtag_d;
  logic          c_gnt, d_gnt;
  logic          wait_sat, wait_clr, wait_inc;
  logic [AW-1:0] m_addr;

  dmem_arb_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_cnt (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .clr   (wait_clr),
    .inc   (wait_inc),
    .sat_c (wait_sat)
  );

  // State and read-tag registers.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= ARB;
      rtag_q  <= TAG_NONE;
    end else begin
      state_q <= state_d;
      rtag_q  <= rtag_d;
    end
  end

  // Next-state: enter lock on a locked debug grant, leave when the lock drops.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB:     if (d_gnt && bus.D_LOCK) state_d = DLOCK;
      DLOCK:   if (!bus.D_LOCK)         state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  // Grants, memory mux, starvation counter control and response routing.
  always_comb begin
    c_gnt    = 1'b0;
    d_gnt    = 1'b0;
    rtag_d   = TAG_NONE;
    wait_clr = 1'b0;
    wait_inc = 1'b0;
    m_addr   = '0;

    if (RSTN) begin
      unique case (state_q)
        ARB: begin
          if (bus.D_REQ && (wait_sat || !bus.C_REQ)) d_gnt = 1'b1;
          else if (bus.C_REQ)                        c_gnt = 1'b1;
        end
        DLOCK:   d_gnt = bus.D_REQ;
        default: ;
      endcase
    end

    wait_clr = d_gnt || !bus.D_REQ;
    wait_inc = bus.D_REQ && !d_gnt && (state_q == ARB);

    if (d_gnt && is_read(bus.D_WSTB))      rtag_d = TAG_D;
    else if (c_gnt && is_read(bus.C_WSTB)) rtag_d = TAG_C;

    m_addr      = d_gnt ? bus.D_ADDR : bus.C_ADDR;
    bus.C_GNT   = c_gnt;
    bus.D_GNT   = d_gnt;
    bus.M_EN    = c_gnt | d_gnt;
    bus.M_WSTB  = d_gnt ? bus.D_WSTB : (c_gnt ? bus.C_WSTB : '0);
    bus.M_ADDR  = m_addr;
    bus.M_WDATA = d_gnt ? bus.D_WDATA : bus.C_WDATA;

    // A read in flight when reset is applied never returns.
    bus.C_RVALID = RSTN && (rtag_q == TAG_C);
    bus.D_RVALID = RSTN && (rtag_q == TAG_D);
    bus.C_RDATA  = bus.M_RDATA;
    bus.D_RDATA  = bus.M_RDATA;
  end

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      PERF_C_GNT   <= '0;
      PERF_D_GNT   <= '0;
      PERF_C_STALL <= '0;
    end else begin
      if (c_gnt)                 PERF_C_GNT   <= PERF_C_GNT + 32'd1;
      if (d_gnt)                 PERF_D_GNT   <= PERF_D_GNT + 32'd1;
      if (bus.C_REQ && !c_gnt)   PERF_C_STALL <= PERF_C_STALL + 32'd1;
    end
  end
`endif

endmodule
